// File: rtl/cb_heep_timer.sv
// Register-bus timer peripheral: prescaled up-counter with compare match, overflow flag
// and a level interrupt, accessed through reg_req_t / reg_rsp_t transactions.
package reg_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module cb_heep_timer #(
  parameter type         reg_req_t   = reg_pkg::reg_req_t,
  parameter type         reg_rsp_t   = reg_pkg::reg_rsp_t,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     irq_o
);

  localparam int unsigned CW = CNT_WIDTH;
  localparam int unsigned PW = PRESC_WIDTH;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_COUNT  = 2'd1;
  localparam logic [1:0] SEL_CMP    = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic          en_q, en_d, auto_q, auto_d, irqen_q, irqen_d;
  logic [PW-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
  logic [CW-1:0] count_q, count_d, cmp_q, cmp_d;
  logic          match_q, match_d, ovf_q, ovf_d;

  logic          misaligned, req_ok, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [1:0]    sel;
  logic          tick, hit, match_set, ovf_set;
  logic [31:0]   rd_mux;
  logic          unused_addr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_addr = ^reg_req_i.addr[31:4];

  // Address decode; misaligned accesses are rejected and never write
  always_comb begin
    sel        = reg_req_i.addr[3:2];
    misaligned = reg_req_i.valid & (reg_req_i.addr[1:0] != 2'b00);
    req_ok     = reg_req_i.valid & ~misaligned;
    wr_ctrl    = req_ok & reg_req_i.write & (sel == SEL_CTRL);
    wr_count   = req_ok & reg_req_i.write & (sel == SEL_COUNT);
    wr_cmp     = req_ok & reg_req_i.write & (sel == SEL_CMP);
    wr_status  = req_ok & reg_req_i.write & (sel == SEL_STATUS);
  end

  // Prescaler and CTRL update
  always_comb begin
    tick        = en_q & (presc_cnt_q == presc_q);
    presc_cnt_d = (wr_ctrl | ~en_q | tick) ? '0 : presc_cnt_q + PW'(1);
    en_d        = en_q;
    auto_d      = auto_q;
    irqen_d     = irqen_q;
    presc_d     = presc_q;
    if (wr_ctrl && reg_req_i.wstrb[0]) begin
      en_d    = reg_req_i.wdata[0];
      auto_d  = reg_req_i.wdata[1];
      irqen_d = reg_req_i.wdata[2];
    end
    if (wr_ctrl && reg_req_i.wstrb[1]) begin
      presc_d = reg_req_i.wdata[8 +: PW];
    end
  end

  // Counter and flags; a software COUNT write overrides the tick increment
  always_comb begin
    hit       = (count_q == cmp_q);
    count_d   = count_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;
    if (tick) begin
      match_set = hit;
      if (hit && auto_q) begin
        count_d = '0;
      end else begin
        ovf_set = (count_q == '1);
        count_d = count_q + CW'(1);
      end
    end
    if (wr_count) begin
      count_d = CW'(byte_merge(32'(count_q), reg_req_i.wdata, reg_req_i.wstrb));
    end
    cmp_d = cmp_q;
    if (wr_cmp) begin
      cmp_d = CW'(byte_merge(32'(cmp_q), reg_req_i.wdata, reg_req_i.wstrb));
    end
    match_d = match_q;
    ovf_d   = ovf_q;
    if (wr_status && reg_req_i.wstrb[0]) begin
      match_d = match_q & ~reg_req_i.wdata[0];
      ovf_d   = ovf_q & ~reg_req_i.wdata[1];
    end
    match_d = match_d | match_set;
    ovf_d   = ovf_d | ovf_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irqen_q     <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      count_q     <= '0;
      cmp_q       <= '1;
      match_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      irqen_q     <= irqen_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      match_q     <= match_d;
      ovf_q       <= ovf_d;
    end
  end

  // Read mux and response; zero wait states
  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_CTRL: begin
        rd_mux[0]       = en_q;
        rd_mux[1]       = auto_q;
        rd_mux[2]       = irqen_q;
        rd_mux[8 +: PW] = presc_q;
      end
      SEL_COUNT:  rd_mux = 32'(count_q);
      SEL_CMP:    rd_mux = 32'(cmp_q);
      SEL_STATUS: rd_mux = {30'd0, ovf_q, match_q};
      default:    rd_mux = '0;
    endcase
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = misaligned;
    reg_rsp_o.rdata = (req_ok && !reg_req_i.write) ? rd_mux : 32'd0;
  end

  assign irq_o = irqen_q & (match_q | ovf_q);

endmodule

// File: tb/tb_cb_heep_timer.sv
// Scoreboard bench for cb_heep_timer: directed scenarios plus random register traffic,
// checked against a behavioural timer model kept in plain integer arithmetic.
module tb_cb_heep_timer;

  logic              clk;
  logic              rst_ni;
  reg_pkg::reg_req_t req;
  reg_pkg::reg_rsp_t rsp;
  logic              irq;

  cb_heep_timer dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .reg_req_i(req),
    .reg_rsp_o(rsp),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   in_rst;

  // Reference model state
  bit          m_en, m_ar, m_ie, m_match, m_ovf;
  int unsigned m_presc, m_phase, m_count, m_cmp;

  function automatic int unsigned bmerge(input int unsigned old_v, input int unsigned new_v,
                                         input logic [3:0] be);
    int unsigned r = 0;
    for (int b = 0; b < 4; b++) begin
      r |= (be[b] ? new_v : old_v) & (32'hFF << (8 * b));
    end
    return r;
  endfunction

  function automatic int unsigned m_ctrl();
    return int'(m_en) + 2 * int'(m_ar) + 4 * int'(m_ie) + 256 * m_presc;
  endfunction

  function automatic int unsigned m_read(input int sel);
    case (sel)
      0:       return m_ctrl();
      1:       return m_count;
      2:       return m_cmp;
      default: return int'(m_match) + 2 * int'(m_ovf);
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_presc = 0; m_phase = 0;
    m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_ovf = 0;
  endtask

  // Advance the model across one clock edge given the request held during that cycle
  task automatic model_step(input bit v, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    bit          fire, set_m, set_o;
    int unsigned old_count, c;
    if (in_rst) return;
    fire      = m_en && (m_phase == m_presc);
    set_m     = 0;
    set_o     = 0;
    old_count = m_count;
    m_phase   = (m_en && !fire) ? m_phase + 1 : 0;
    if (fire) begin
      set_m = (m_count == m_cmp);
      if (set_m && m_ar) m_count = 0;
      else if (m_count == 32'hFFFF_FFFF) begin m_count = 0; set_o = 1; end
      else m_count = m_count + 1;
    end
    if (v && w && a[1:0] == 2'b00) begin
      case (int'(a[3:2]))
        0: begin
          c       = bmerge(m_ctrl(), d, s);
          m_en    = c[0];
          m_ar    = c[1];
          m_ie    = c[2];
          m_presc = (c >> 8) & 255;
          m_phase = 0;
        end
        1: m_count = bmerge(old_count, d, s);
        2: m_cmp   = bmerge(m_cmp, d, s);
        default: if (s[0]) begin
          if (d[0]) m_match = 0;
          if (d[1]) m_ovf = 0;
        end
      endcase
    end
    if (set_m) m_match = 1;
    if (set_o) m_ovf = 1;
  endtask

  // Drive one bus cycle and queue the response the model expects for it
  task automatic cyc(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit use_c, input logic [31:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    e.err   = v && (a[1:0] != 2'b00);
    e.rdata = (v && !w && !e.err) ? (use_c ? c : 32'(m_read(int'(a[3:2])))) : 32'd0;
    e.irq   = m_ie && (m_match || m_ovf);
    q.push_back(e);
    model_step(v, w, a, d, s);
  endtask

  task automatic idle();                                  cyc(0, 0, 0, 0, 0, 0, 0);    endtask
  task automatic rd(input logic [31:0] a);                cyc(1, 0, a, 0, 0, 0, 0);    endtask
  task automatic rd_c(input logic [31:0] a, input logic [31:0] c); cyc(1, 0, a, 0, 0, 1, c); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);   cyc(1, 1, a, d, 4'hF, 0, 0); endtask
  task automatic wr_s(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc(1, 1, a, d, s, 0, 0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    in_rst = 1'b1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    req    = '0;
    rst_ni = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
  endtask

  // Monitor: every driven cycle presents a response, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rdata", rsp.rdata, e.rdata);
      chk("error", 32'(rsp.error), 32'(e.err));
      chk("irq",   32'(irq), 32'(e.irq));
      chk("ready", 32'(rsp.ready), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          sel;
    req    = '0;
    rst_ni = 1'b0;
    in_rst = 1'b1;
    model_reset();

    // Reset values
    idle();
    rd_c(32'h0, 32'h0);
    release_reset();
    rd_c(32'h0, 32'h0);
    rd_c(32'h4, 32'h0);
    rd_c(32'h8, 32'hFFFF_FFFF);
    rd_c(32'hC, 32'h0);

    // Auto-reload compare with interrupt, then W1C
    wr(32'h8, 5);
    wr(32'h0, 32'h7);
    for (int i = 0; i <= 5; i++) rd_c(32'h4, 32'(i));
    rd_c(32'h4, 32'h0);
    rd_c(32'hC, 32'h1);
    wr(32'hC, 32'h1);
    rd_c(32'hC, 32'h0);
    wr(32'h0, 32'h0);

    // Prescaler of 4
    wr(32'h4, 0);
    wr(32'h0, 32'h0301);
    repeat (40) idle();
    rd_c(32'h4, 32'd10);
    wr(32'h0, 32'h0);

    // Overflow without interrupt enable
    wr(32'hC, 32'h3);
    wr(32'h4, 32'hFFFF_FFFE);
    wr(32'h8, 32'd10);
    wr(32'h0, 32'h1);
    idle();
    idle();
    rd_c(32'h4, 32'h0);
    rd_c(32'hC, 32'h2);
    wr(32'h0, 32'h0);

    // Collisions: W1C against new match, COUNT write against tick
    wr(32'hC, 32'h3);
    wr(32'h4, 0);
    wr(32'h8, 2);
    wr(32'h0, 32'h3);
    idle();
    idle();
    wr(32'hC, 32'h1);
    rd_c(32'hC, 32'h1);
    wr(32'h4, 32'h100);
    rd_c(32'h4, 32'h100);
    wr(32'h0, 32'h0);

    // Byte strobes and alignment
    wr(32'h8, 32'hFFFF_FFFF);
    wr_s(32'h8, 32'h1234_5678, 4'b0001);
    rd_c(32'h8, 32'hFFFF_FF78);
    wr(32'h9, 32'h0);
    rd_c(32'h8, 32'hFFFF_FF78);
    rd(32'h6);
    rd_c(32'hABCD_0008, 32'hFFFF_FF78);

    // Asynchronous reset mid-count
    wr(32'h8, 7);
    wr(32'h0, 32'h0107);
    repeat (10) idle();
    assert_reset();
    rd_c(32'h0, 32'h0);
    rd_c(32'h4, 32'h0);
    rd_c(32'h8, 32'hFFFF_FFFF);
    rd_c(32'hC, 32'h0);
    release_reset();

    // Random register traffic
    repeat (1500) begin
      sel = int'($urandom_range(0, 3));
      a   = {$urandom_range(0, 15) == 0 ? 28'($urandom) : 28'd0, 2'(sel), 2'b00};
      if ($urandom_range(0, 19) == 0) a[1:0] = 2'($urandom_range(1, 3));
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      case (sel)
        0:       d = {16'($urandom), 8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
        1:       d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 20));
        2:       d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
        default: d = 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: idle();
        4, 5, 6:    cyc(1, 0, a, 0, 0, 0, 0);
        default:    cyc(1, 1, a, d, s, 0, 0);
      endcase
    end

    @(posedge clk);
    #1;
    req = '0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
